// File: rtl/line_buffer.sv
// line_buffer: single-row RGB delay line. Every accepted pixel is written into
// a circular row memory; once a full row is stored, the pixel from the same
// column one row earlier is emitted with a one-cycle valid strobe.
module line_buffer #(
    parameter int IMG_WIDTH   = 640,
    parameter int PXL_CHANNEL = 8,
    localparam int CW         = $clog2(IMG_WIDTH)
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_enable_rx,
    input  logic [2:0][PXL_CHANNEL-1:0]  i_data,
    input  logic                         i_flush,
    output logic [2:0][PXL_CHANNEL-1:0]  o_data,
    output logic                         o_enable_tx,
    output logic [CW-1:0]                o_col,
    output logic                         o_eol,
    output logic                         o_full
);

    // fill must be able to hold IMG_WIDTH itself, hence one extra bit
    localparam logic [CW:0]   FILL_MAX = (CW+1)'(IMG_WIDTH);
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);

    logic [2:0][PXL_CHANNEL-1:0] mem [IMG_WIDTH];
    logic [CW-1:0]               wr_ptr;
    logic [CW:0]                 fill;
    logic                        beat;

    // flush has priority: a beat arriving with flush is dropped entirely
    assign beat = i_enable_rx && !i_flush;

    // Row memory write; contents are never reset so this can map to block RAM
    always_ff @(posedge i_clk) begin
        if (beat) begin
            mem[wr_ptr] <= i_data;
        end
    end

    // Pointer/fill bookkeeping and registered outputs (read-before-write at wr_ptr)
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wr_ptr      <= '0;
            fill        <= '0;
            o_data      <= '0;
            o_enable_tx <= 1'b0;
            o_col       <= '0;
            o_eol       <= 1'b0;
            o_full      <= 1'b0;
        end else if (i_flush) begin
            // o_data and o_col deliberately hold across a flush
            wr_ptr      <= '0;
            fill        <= '0;
            o_enable_tx <= 1'b0;
            o_eol       <= 1'b0;
            o_full      <= 1'b0;
        end else if (beat) begin
            o_data      <= mem[wr_ptr];
            o_col       <= wr_ptr;
            o_eol       <= (wr_ptr == LAST_COL);
            o_enable_tx <= (fill == FILL_MAX);
            wr_ptr      <= (wr_ptr == LAST_COL) ? '0 : wr_ptr + 1'b1;
            if (fill != FILL_MAX) begin
                fill <= fill + 1'b1;
            end
            // fill saturates, so "reaches or already at max" after this beat
            o_full      <= (fill >= FILL_MAX - 1'b1);
        end else begin
            o_enable_tx <= 1'b0;
        end
    end

endmodule
